// File: rtl/flash_burst_reader.sv
// Burst sequencer in front of the W25Q32JV fast-read engine: splits a burst into
// 2-byte fast-read transactions and streams the returned bytes out one at a time.
module flash_burst_reader #(
  parameter int FLASH_BYTES  = 4194304,
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [23:0]      start_addr,
  input  logic [CNT_W-1:0] byte_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             fr_start,
  output logic [23:0]      fr_addr,
  input  logic             fr_done,
  input  logic [7:0]       fr_data_1,
  input  logic [7:0]       fr_data_2,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_FINISH
  } state_t;

  localparam int                TCNT_W    = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [23:0]       ADDR_MASK = 24'(FLASH_BYTES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(WAIT_TIMEOUT - 1);

  state_t             state, next_state;
  logic [23:0]        cur_addr;
  logic [CNT_W-1:0]   remaining;
  logic [7:0]         buf0, buf1;
  logic [1:0]         nbuf;
  logic [TCNT_W-1:0]  tcnt;
  logic               zero_done;
  logic               error_q;

  logic               accept_start;
  logic               timeout;
  logic [1:0]         take;

  assign accept_start = (state == S_IDLE) && start && (byte_count != '0);
  assign timeout      = (state == S_WAIT) && !fr_done && (tcnt == TCNT_LAST);
  // Bytes kept from this transaction: the odd tail drops fr_data_2.
  assign take         = (remaining >= CNT_W'(2)) ? 2'd2 : remaining[1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (accept_start) next_state = S_ISSUE;
      S_ISSUE:  next_state = S_WAIT;
      S_WAIT: begin
        if (fr_done)      next_state = S_DRAIN;
        else if (timeout) next_state = S_IDLE;
      end
      S_DRAIN: begin
        if (m_ready && nbuf == 2'd1)
          next_state = (remaining != '0) ? S_ISSUE : S_FINISH;
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_FINISH) || zero_done;
    error    = error_q;
    fr_start = (state == S_ISSUE);
    fr_addr  = '0;
    m_valid  = (state == S_DRAIN);
    m_data   = '0;
    if (state == S_ISSUE || state == S_WAIT) fr_addr = cur_addr;
    if (state == S_DRAIN)                    m_data  = buf0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      buf0      <= '0;
      buf1      <= '0;
      nbuf      <= '0;
      tcnt      <= '0;
      zero_done <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      zero_done <= (state == S_IDLE) && start && (byte_count == '0);
      error_q   <= timeout;
      case (state)
        S_IDLE: begin
          if (accept_start) begin
            cur_addr  <= start_addr & ADDR_MASK;
            remaining <= byte_count;
          end
        end
        S_ISSUE: tcnt <= '0;
        S_WAIT: begin
          if (fr_done) begin
            buf0      <= fr_data_1;
            buf1      <= fr_data_2;
            nbuf      <= take;
            remaining <= remaining - CNT_W'(take);
            cur_addr  <= (cur_addr + 24'd2) & ADDR_MASK;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (m_ready) begin
            buf0 <= buf1;
            nbuf <= nbuf - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_burst_reader.sv
// Scoreboard bench for flash_burst_reader: directed bursts push expected addresses
// and bytes into queues, a negedge monitor pops and compares on each DUT event.
module tb_flash_burst_reader;

  localparam int T_OUT = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] start_addr;
  logic [15:0] byte_count;
  logic        busy, done, error, fr_start;
  logic [23:0] fr_addr;
  logic        fr_done;
  logic [7:0]  fr_data_1, fr_data_2;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fs_cnt, hs_cnt, done_cnt, err_cnt;
  bit flash_en = 1'b1;

  logic [23:0] addr_q[$];
  logic [7:0]  byte_q[$];

  flash_burst_reader #(.FLASH_BYTES(4194304), .CNT_W(16), .WAIT_TIMEOUT(T_OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .byte_count(byte_count), .busy(busy), .done(done), .error(error),
    .fr_start(fr_start), .fr_addr(fr_addr), .fr_done(fr_done),
    .fr_data_1(fr_data_1), .fr_data_2(fr_data_2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inputs change 2 time units after the rising edge, well clear of sampling.
  task automatic drv();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] fdata(input logic [23:0] a);
    return a[7:0] ^ 8'hA0;
  endfunction

  // Fast-read engine model: answers 3 cycles after fr_start, flash wraps at 4 MiB.
  initial begin
    logic [23:0] a;
    fr_done = 1'b0; fr_data_1 = '0; fr_data_2 = '0;
    forever begin
      @(negedge clk);
      if (fr_start && flash_en) begin
        a = fr_addr;
        repeat (2) drv();
        fr_data_1 = fdata(a);
        fr_data_2 = fdata((a + 24'd1) & 24'h3FFFFF);
        fr_done   = 1'b1;
        drv();
        fr_done   = 1'b0;
        fr_data_1 = '0;
        fr_data_2 = '0;
      end
    end
  end

  // Monitor: compares every fr_start address and every accepted byte.
  always @(negedge clk) begin
    if (fr_start) begin
      fs_cnt++;
      if (addr_q.size() == 0) check("fr_addr_unexpected", {8'h0, fr_addr}, 32'hFFFFFFFF);
      else                    check("fr_addr", {8'h0, fr_addr}, {8'h0, addr_q.pop_front()});
    end
    if (m_valid && m_ready) begin
      hs_cnt++;
      if (byte_q.size() == 0) check("m_data_unexpected", {24'h0, m_data}, 32'hFFFFFFFF);
      else                    check("m_data", {24'h0, m_data}, {24'h0, byte_q.pop_front()});
    end
    if (done)  done_cnt++;
    if (error) err_cnt++;
  end

  task automatic clear_counts();
    fs_cnt = 0; hs_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic run_burst(input logic [23:0] addr, input logic [15:0] cnt);
    drv();
    start_addr = addr;
    byte_count = cnt;
    start      = 1'b1;
    drv();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && !error && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!m_valid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_m_valid"}, {31'd0, m_valid}, 32'd1);
  endtask

  task automatic end_burst(input string name, input int fs_exp, input int hs_exp);
    @(negedge clk);
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({name, "_fr_starts"}, fs_cnt, fs_exp);
    check({name, "_handshakes"}, hs_cnt, hs_exp);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_bytes_left"}, byte_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int changes;
    logic [7:0] held;
    rst = 1'b1; start = 1'b0; start_addr = '0; byte_count = '0; m_ready = 1'b1;
    clear_counts();
    repeat (3) drv();
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_fr_start", {31'd0, fr_start}, 0);
    check("rst_fr_addr", {8'h0, fr_addr}, 0);
    check("rst_m_valid", {31'd0, m_valid}, 0);
    check("rst_m_data", {24'h0, m_data}, 0);
    drv();
    rst = 1'b0;

    // Even burst
    clear_counts();
    addr_q = '{24'h000100, 24'h000102};
    byte_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    run_burst(24'h000100, 16'd4);
    @(negedge clk);
    check("even_busy", {31'd0, busy}, 1);
    wait_done("even");
    end_burst("even", 2, 4);

    // Odd burst: second pair's fr_data_2 is dropped
    clear_counts();
    addr_q = '{24'h000200, 24'h000202};
    byte_q = '{8'hA0, 8'hA1, 8'hA2};
    run_burst(24'h000200, 16'd3);
    wait_done("odd");
    end_burst("odd", 2, 3);

    // Backpressure, with a start issued while busy
    clear_counts();
    m_ready = 1'b0;
    addr_q = '{24'h000010, 24'h000012};
    byte_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    run_burst(24'h000010, 16'd4);
    wait_valid("bp");
    held = m_data;
    run_burst(24'h000777, 16'd6);
    changes = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (!m_valid || m_data !== held) changes++;
    end
    check("bp_m_data_stable", changes, 0);
    check("bp_no_second_fr_start", fs_cnt, 1);
    drv();
    m_ready = 1'b1;
    wait_done("bp");
    end_burst("bp", 2, 4);

    // Address wrap at the top of flash
    clear_counts();
    addr_q = '{24'h3FFFFF, 24'h000001};
    byte_q = '{8'h5F, 8'hA0, 8'hA1, 8'hA2};
    run_burst(24'h3FFFFF, 16'd4);
    wait_done("wrap");
    end_burst("wrap", 2, 4);

    // Zero-length burst
    clear_counts();
    run_burst(24'h000123, 16'd0);
    @(negedge clk);
    check("zero_done", {31'd0, done}, 1);
    check("zero_busy", {31'd0, busy}, 0);
    repeat (5) @(negedge clk);
    check("zero_fr_starts", fs_cnt, 0);
    check("zero_done_pulses", done_cnt, 1);

    // Timeout: engine never answers
    clear_counts();
    flash_en = 1'b0;
    addr_q = '{24'h000040};
    run_burst(24'h000040, 16'd2);
    @(negedge clk);
    check("to_fr_start", {31'd0, fr_start}, 1);
    cyc = 0;
    while (cyc < 3 * T_OUT) begin
      @(negedge clk);
      if (error) break;
      cyc++;
    end
    check("to_latency", cyc, T_OUT);
    check("to_busy_at_error", {31'd0, busy}, 0);
    @(negedge clk);
    check("to_error_pulses", err_cnt, 1);
    check("to_error_cleared", {31'd0, error}, 0);
    check("to_done_pulses", done_cnt, 0);
    flash_en = 1'b1;
    clear_counts();
    addr_q = '{24'h000300};
    byte_q = '{8'hA0, 8'hA1};
    run_burst(24'h000300, 16'd2);
    wait_done("post_to");
    end_burst("post_to", 1, 2);

    // Reset while draining
    clear_counts();
    m_ready = 1'b0;
    addr_q = '{24'h000500};
    run_burst(24'h000500, 16'd2);
    wait_valid("rst_mid");
    drv();
    rst = 1'b1;
    drv();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_m_valid", {31'd0, m_valid}, 0);
    check("rst_mid_m_data", {24'h0, m_data}, 0);
    check("rst_mid_fr_start", {31'd0, fr_start}, 0);
    repeat (4) @(negedge clk);
    check("rst_mid_done_pulses", done_cnt, 0);
    check("rst_mid_error_pulses", err_cnt, 0);
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_handshakes", hs_cnt, 0);
    check("final_addr_q_empty", addr_q.size(), 0);
    check("final_byte_q_empty", byte_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
